amba_apb_master: RTL and testbench



---
 rtl/amba_apb_master.sv | 115 +++++++++++
 tb/tb_amba_apb_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_apb_master.sv
// APB initiator: converts a valid/ready command into one APB SETUP/ACCESS
// transfer and reports exactly one response per accepted command.
// A programmable timeout aborts a transfer whose slave never raises pready.
//
// Handshake: a command transfers on a rising pclk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is registered and high only in IDLE, so
// cmd_valid while busy has no effect. rsp_valid is a one-cycle pulse that is
// not back-pressured. rsp_rdata/rsp_err hold until the next completion.
module amba_apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter is sized to hold TIMEOUT; with the timeout disabled a 1-bit
  // counter that saturates is enough.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // Value of the counter during the TIMEOUT-th consecutive low-pready cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cmd_ready <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
            wait_cnt  <= wait_cnt + 1'b1;
            state     <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amba_apb_master.sv
// Directed bench for amba_apb_master: a TIMEOUT=16 instance backed by a small
// APB memory, plus a TIMEOUT=0 instance for the disabled-timeout case.
module tb_amba_apb_master;

  logic       pclk = 1'b0;
  logic       preset;

  // TIMEOUT=16 instance
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready;
  logic [7:0] prdata, prdata_drv;
  logic       use_mem;
  logic [7:0] mem [256];

  // TIMEOUT=0 instance
  logic       cmd_valid1, cmd_ready1, cmd_write1;
  logic [7:0] cmd_addr1, cmd_wdata1;
  logic       rsp_valid1, rsp_err1;
  logic [7:0] rsp_rdata1;
  logic       psel1, penable1, pwrite1;
  logic [7:0] paddr1, pwdata1;
  logic       pready1;
  logic [7:0] prdata1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 pclk = ~pclk;

  amba_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) u0 (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  amba_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(0)) u1 (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write1),
    .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .psel(psel1), .penable(penable1), .pwrite(pwrite1), .paddr(paddr1), .pwdata(pwdata1),
    .pready(pready1), .prdata(prdata1)
  );

  // APB memory slave model: combinational read, write on the completing edge
  assign prdata = use_mem ? mem[paddr] : prdata_drv;
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  // advance one edge and settle
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== 19'h0) begin
      n_fail++; $display("FAIL reset_apb got=%h exp=0", {psel, penable, pwrite, paddr, pwdata});
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== 11'h0) begin
      n_fail++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_rdata, cmd_ready});
    end
    preset = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write();
    use_mem = 1'b1; pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'hA5;
    tick();  // E
    cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, cmd_ready} !== {3'b101, 8'h10, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL wr_setup got=%h exp=%h", {psel, penable, pwrite, paddr, pwdata, cmd_ready},
                         {3'b101, 8'h10, 8'hA5, 1'b0});
    end
    tick();  // E+1
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {3'b111, 8'h10, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL wr_access got=%h exp=%h", {psel, penable, pwrite, paddr, pwdata, rsp_valid},
                         {3'b111, 8'h10, 8'hA5, 1'b0});
    end
    tick();  // E+2
    n_checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {4'b0010, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL wr_done got=%h exp=%h", {psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready},
                         {4'b0010, 8'h00, 1'b1});
    end
    n_checks++;
    if (mem[8'h10] !== 8'hA5) begin
      n_fail++; $display("FAIL wr_mem got=%h exp=a5", mem[8'h10]);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_pulse_len got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    int ready_low = 0;
    int en_high = 0;
    use_mem = 1'b0; prdata_drv = 8'h5A; pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
    tick();  // E
    cmd_valid = 1'b0;
    if (cmd_ready == 1'b0) ready_low++;
    tick();  // E+1
    if (cmd_ready == 1'b0) ready_low++;
    if (penable) en_high++;
    tick();  // E+2, pready low
    if (cmd_ready == 1'b0) ready_low++;
    if (penable) en_high++;
    tick();  // E+3, pready low
    if (cmd_ready == 1'b0) ready_low++;
    if (penable) en_high++;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_early_rsp got=%b exp=0", rsp_valid);
    end
    pready = 1'b1;
    tick();  // E+4
    if (cmd_ready == 1'b0) ready_low++;
    if (penable) en_high++;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel} !== {2'b10, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL rd_done got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata, psel}, {2'b10, 8'h5A, 1'b0});
    end
    n_checks++;
    if (en_high !== 3) begin
      n_fail++; $display("FAIL rd_penable_cycles got=%0d exp=3", en_high);
    end
    n_checks++;
    if (ready_low !== 4) begin
      n_fail++; $display("FAIL rd_ready_low got=%0d exp=4", ready_low);
    end
    prdata_drv = 8'hC3;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL rd_hold got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b0, 8'h5A});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    use_mem = 1'b0; prdata_drv = 8'hEE; pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33;
    tick();  // E
    cmd_valid = 1'b0;
    tick();  // E+1
    while (penable && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== 16) begin
      n_fail++; $display("FAIL to_access_len got=%0d exp=16", n);
    end
    n_checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {4'b0011, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL to_abort got=%h exp=%h", {psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready},
                         {4'b0011, 8'h00, 1'b1});
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_err} !== 2'b01) begin
      n_fail++; $display("FAIL to_err_hold got=%b exp=01", {rsp_valid, rsp_err});
    end
  endtask

  task automatic test_timeout_disabled();
    int bad = 0;
    pready1 = 1'b0; prdata1 = 8'h3C;
    cmd_valid1 = 1'b1; cmd_write1 = 1'b0; cmd_addr1 = 8'h55;
    tick();
    cmd_valid1 = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      if (!(psel1 && penable1) || rsp_valid1) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL to0_no_abort got=%0d bad cycles exp=0", bad);
    end
    pready1 = 1'b1;
    tick();
    n_checks++;
    if ({rsp_valid1, rsp_err1, rsp_rdata1, psel1} !== {2'b10, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL to0_done got=%h exp=%h", {rsp_valid1, rsp_err1, rsp_rdata1, psel1},
                         {2'b10, 8'h3C, 1'b0});
    end
    pready1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       w_tab [4];
    logic [7:0] a_tab [4];
    logic [7:0] d_tab [4];
    int idx = 0, n_rsp = 0, cyc = 0, last_acc = -1, bad_gap = 0, low_run = 0, bad_low = 0;
    logic pre_ready, seen_psel;
    w_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    a_tab = '{8'h01, 8'h02, 8'h01, 8'h02};
    d_tab = '{8'h11, 8'h22, 8'h00, 8'h00};
    exp_q = {8'h00, 8'h00, 8'h11, 8'h22};
    use_mem = 1'b1; pready = 1'b1; seen_psel = 1'b0;
    cmd_valid = 1'b1; cmd_write = w_tab[0]; cmd_addr = a_tab[0]; cmd_wdata = d_tab[0];
    while (n_rsp < 4 && cyc < 60) begin
      pre_ready = cmd_ready;
      tick();
      cyc++;
      if (pre_ready && cmd_valid) begin
        if (last_acc >= 0 && cyc - last_acc != 3) bad_gap++;
        last_acc = cyc;
        idx++;
        if (idx < 4) begin
          cmd_write = w_tab[idx]; cmd_addr = a_tab[idx]; cmd_wdata = d_tab[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (psel) begin
        if (seen_psel && low_run != 0 && low_run != 1) bad_low++;
        seen_psel = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (rsp_valid) begin
        n_rsp++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_rsp got=%h exp=none", rsp_rdata);
        end else if ({rsp_err, rsp_rdata} !== {1'b0, exp_q[0]}) begin
          n_fail++; $display("FAIL b2b_rsp got=%h exp=%h", {rsp_err, rsp_rdata}, {1'b0, exp_q[0]});
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (n_rsp !== 4 || idx !== 4) begin
      n_fail++; $display("FAIL b2b_count got=%0d rsp %0d acc exp=4 4", n_rsp, idx);
    end
    n_checks++;
    if (bad_gap !== 0 || bad_low !== 0) begin
      n_fail++; $display("FAIL b2b_spacing got=%0d bad gaps %0d bad psel-low exp=0 0", bad_gap, bad_low);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    int n_rsp = 0;
    use_mem = 1'b1; pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h77;
    tick();  // accept
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      cmd_addr  = 8'h80 + 8'(i);
      cmd_wdata = 8'h90 + 8'(i);
      if (i == 3) pready = 1'b1;
      tick();
      if (rsp_valid) begin
        n_rsp++;
        cmd_valid = 1'b0;
        pready = 1'b0;
      end
      n_checks++;
      if (n_rsp == 0 && {paddr, pwdata} !== {8'h40, 8'h77}) begin
        n_fail++; $display("FAIL busy_stable got=%h exp=%h", {paddr, pwdata}, {8'h40, 8'h77});
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) n_rsp++;
    end
    n_checks++;
    if (n_rsp !== 1 || psel !== 1'b0) begin
      n_fail++; $display("FAIL busy_one_rsp got=%0d psel=%b exp=1 psel=0", n_rsp, psel);
    end
    n_checks++;
    if ({mem[8'h40], mem[8'h81], mem[8'h83]} !== {8'h77, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL busy_mem got=%h exp=%h", {mem[8'h40], mem[8'h81], mem[8'h83]}, {8'h77, 16'h0});
    end
  endtask

  task automatic test_reset_mid();
    int n_rsp = 0;
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21;
    tick();
    cmd_valid = 1'b0;
    tick();  // now in ACCESS
    n_checks++;
    if ({psel, penable} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_pre got=%b exp=11", {psel, penable});
    end
    preset = 1'b1;
    tick();
    n_checks++;
    if ({psel, penable, rsp_valid, cmd_ready, paddr} !== 12'h0) begin
      n_fail++; $display("FAIL rst_mid_clear got=%h exp=0", {psel, penable, rsp_valid, cmd_ready, paddr});
    end
    pready = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ready_low got=%b exp=0", cmd_ready);
    end
    preset = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready_rise got=%b exp=1", cmd_ready);
    end
    if (rsp_valid) n_rsp++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) n_rsp++;
    end
    n_checks++;
    if (n_rsp !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", n_rsp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    cmd_valid1 = 1'b0; cmd_write1 = 1'b0; cmd_addr1 = 8'h00; cmd_wdata1 = 8'h00;
    pready = 1'b0; pready1 = 1'b0; prdata1 = 8'h00;
    prdata_drv = 8'h00; use_mem = 1'b1;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_timeout_disabled();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
